// File: rtl/uarttx.sv
// 8N1 UART transmitter paced by a shared 16x baud enable, with a single-entry
// holding register so the next byte can be queued while a frame is shifting.
module uarttx (
    input  logic       clk,
    input  logic       reset,
    input  logic       bclk,
    input  logic [7:0] din,
    input  logic       load,
    output logic       txd,
    output logic       empty,
    output logic       busy,
    output logic       overrun,
    output logic [3:0] CS
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] STARTBIT = 4'd1;
    localparam logic [3:0] BIT0     = 4'd2;
    localparam logic [3:0] BIT7     = 4'd9;
    localparam logic [3:0] STOPBIT  = 4'd10;

    logic [3:0] state_reg,     state_next;
    logic [3:0] bitcnt_reg,    bitcnt_next;
    logic [7:0] hold_reg,      hold_next;
    logic       hold_full_reg, hold_full_next;
    logic [7:0] shreg_reg,     shreg_next;
    logic       txd_reg,       txd_next;
    logic       overrun_reg,   overrun_next;

    logic       bit_end;
    logic       xfer;

    // A state ends on the 16th baud pulse counted since it was entered.
    assign bit_end = bclk && (bitcnt_reg == 4'd15);

    always_comb begin
        state_next     = state_reg;
        bitcnt_next    = bitcnt_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shreg_next     = shreg_reg;
        txd_next       = txd_reg;
        overrun_next   = overrun_reg;
        xfer           = 1'b0;

        if (state_reg == IDLE) begin
            bitcnt_next = 4'd0;
            txd_next    = 1'b1;
            xfer        = hold_full_reg && bclk;
        end else if (state_reg >= STARTBIT && state_reg <= BIT7) begin
            if (bclk) begin
                bitcnt_next = bitcnt_reg + 4'd1;
            end
            if (bit_end) begin
                shreg_next = shreg_reg >> 1;
                if (state_reg == BIT7) begin
                    state_next = STOPBIT;
                    txd_next   = 1'b1;
                end else begin
                    state_next = state_reg + 4'd1;
                    txd_next   = shreg_reg[0];
                end
            end
        end else if (state_reg == STOPBIT) begin
            txd_next = 1'b1;
            if (bclk) begin
                bitcnt_next = bitcnt_reg + 4'd1;
            end
            if (bit_end) begin
                // A queued byte chains straight into the next start bit.
                if (hold_full_reg) begin
                    xfer = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
        end else begin
            state_next  = IDLE;
            bitcnt_next = 4'd0;
            txd_next    = 1'b1;
        end

        if (xfer) begin
            shreg_next     = hold_reg;
            hold_full_next = 1'b0;
            bitcnt_next    = 4'd0;
            state_next     = STARTBIT;
            txd_next       = 1'b0;
        end

        // On the transfer edge the holding register is being vacated, so a
        // concurrent load is accepted rather than flagged as an overrun.
        if (load) begin
            if (!hold_full_reg || xfer) begin
                hold_next      = din;
                hold_full_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= 4'd0;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
            shreg_reg     <= 8'd0;
            txd_reg       <= 1'b1;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bitcnt_reg    <= bitcnt_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shreg_reg     <= shreg_next;
            txd_reg       <= txd_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign txd     = txd_reg;
    assign empty   = !hold_full_reg;
    assign busy    = (state_reg != IDLE);
    assign overrun = overrun_reg;
    assign CS      = state_reg;

endmodule

// File: tb/tb_uarttx.sv
// Bench for uarttx: a frame-timeline model compared every cycle, a mid-bit
// line receiver, and directed scenarios with literal expectations.
module tb_uarttx;

    logic       clk;
    logic       reset;
    logic       bclk;
    logic [7:0] din;
    logic       load;
    logic       txd;
    logic       empty;
    logic       busy;
    logic       overrun;
    logic [3:0] CS;

    int errors = 0;
    int checks = 0;
    int cmp_prints = 0;

    uarttx dut (
        .clk     (clk),
        .reset   (reset),
        .bclk    (bclk),
        .din     (din),
        .load    (load),
        .txd     (txd),
        .empty   (empty),
        .busy    (busy),
        .overrun (overrun),
        .CS      (CS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // bclk: one pulse every 4 clk, changed on the falling edge.
    initial begin
        int cyc;
        cyc  = 0;
        bclk = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bclk = (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a frame is a run of 160 baud pulses; the bit on the line is
    // pulses/16 (0 = start, 1..8 = data LSB first, 9 = stop).
    logic       m_active = 1'b0;
    int         m_pulses = 0;
    logic [7:0] m_byte   = 8'd0;
    logic       m_hv     = 1'b0;
    logic [7:0] m_hold   = 8'd0;
    logic       m_ovr    = 1'b0;

    initial begin
        logic old_hv;
        logic xfer;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 1'b0;
                m_pulses = 0;
                m_hv     = 1'b0;
                m_hold   = 8'd0;
                m_ovr    = 1'b0;
            end else begin
                old_hv = m_hv;
                xfer   = 1'b0;
                if (bclk) begin
                    if (m_active) begin
                        m_pulses++;
                        if (m_pulses == 160) m_active = 1'b0;
                    end
                    if (!m_active && old_hv) begin
                        m_active = 1'b1;
                        m_pulses = 0;
                        m_byte   = m_hold;
                        xfer     = 1'b1;
                    end
                end
                if (xfer) m_hv = 1'b0;
                if (load) begin
                    if (!old_hv || xfer) begin
                        m_hold = din;
                        m_hv   = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] model_outs();
        int         b;
        logic       t;
        logic [3:0] cs;
        if (!m_active) begin
            t  = 1'b1;
            cs = 4'd0;
        end else begin
            b  = m_pulses / 16;
            cs = 4'(b + 1);
            if (b == 0)      t = 1'b0;
            else if (b <= 8) t = m_byte[b-1];
            else             t = 1'b1;
        end
        return {t, !m_hv, m_active, m_ovr, cs};
    endfunction

    initial begin
        logic [7:0] exp_o;
        logic [7:0] act_o;
        forever begin
            @(negedge clk);
            exp_o = model_outs();
            act_o = {txd, empty, busy, overrun, CS};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                if (cmp_prints < 30) begin
                    cmp_prints++;
                    $display("FAIL cycle_compare t=%0t {txd,empty,busy,overrun,CS} got %b expected %b",
                             $time, act_o, exp_o);
                end
            end
        end
    end

    // Line receiver: samples mid-bit, 64 clk per bit.
    logic [7:0] rx_q[$];
    initial begin
        logic       rx_on;
        int         rx_cnt;
        int         k;
        logic [7:0] rx_sh;
        rx_on  = 1'b0;
        rx_cnt = 0;
        rx_sh  = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (txd == 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % 64 == 32) begin
                    k = rx_cnt / 64;
                    if (k == 0) begin
                        chk("rx_start", 32'(txd), 32'd0);
                    end else if (k <= 8) begin
                        rx_sh[k-1] = txd;
                    end else begin
                        chk("rx_stop", 32'(txd), 32'd1);
                        rx_q.push_back(rx_sh);
                        $display("rx byte 0x%02h", rx_sh);
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_load(input logic [7:0] b);
        @(negedge clk); #1;
        din  = b;
        load = 1'b1;
        $display("load 0x%02h", b);
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_cs(input logic [3:0] v, input int limit, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (CS !== v && n < limit);
        if (CS !== v) begin
            errors++;
            checks++;
            $display("FAIL %s: timeout waiting CS=%0d, got CS=%0d", name, v, CS);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && empty === 1'b1) && n < 2000);
        if (!(busy === 1'b0 && empty === 1'b1)) begin
            errors++;
            checks++;
            $display("FAIL %s: timeout waiting idle, busy=%b empty=%b", name, busy, empty);
        end
    endtask

    initial begin
        logic [9:0]  exp_bits;
        logic [7:0]  exp_rx[8];
        int          n;
        reset = 1'b1;
        load  = 1'b0;
        din   = 8'd0;

        // Reset check
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_cs", 32'(CS), 32'd0);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte 0xA5: start, A5 LSB first, stop
        exp_bits = {1'b1, 8'hA5, 1'b0};
        do_load(8'hA5);
        chk("a5_empty_after_load", 32'(empty), 32'd0);
        wait_cs(4'd1, 70, "a5_start");
        chk("a5_start_txd", 32'(txd), 32'd0);
        chk("a5_empty_at_start", 32'(empty), 32'd1);
        for (int off = 1; off <= 640; off++) begin
            @(negedge clk);
            if (off % 64 == 32)
                chk($sformatf("a5_bit%0d", off / 64), 32'(txd), 32'(exp_bits[off / 64]));
            if (off == 639) chk("a5_busy_before_end", 32'(busy), 32'd1);
            if (off == 640) chk("a5_busy_after_end", 32'(busy), 32'd0);
        end
        wait_idle("a5_idle");

        // Back-to-back 0x00 then 0xFF
        do_load(8'h00);
        wait_cs(4'd1, 70, "b2b_start");
        do_load(8'hFF);
        wait_cs(4'd10, 800, "b2b_stop");
        n = 0;
        while (CS === 4'd10 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_no_gap_cs", 32'(CS), 32'd1);
        chk("b2b_no_gap_txd", 32'(txd), 32'd0);
        wait_idle("b2b_idle");

        // Load coinciding with the transfer edge of 0x3C
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (bclk && n < 10);
        din  = 8'h3C;
        load = 1'b1;
        $display("load 0x3c");
        @(negedge clk); #1;
        load = 1'b0;
        n = 0;
        while (!bclk && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        din  = 8'h55;
        load = 1'b1;
        $display("load 0x55 on transfer edge");
        @(negedge clk); #1;
        load = 1'b0;
        chk("simul_cs", 32'(CS), 32'd1);
        chk("simul_empty", 32'(empty), 32'd0);
        chk("simul_overrun", 32'(overrun), 32'd0);
        wait_idle("simul_idle");
        chk("simul_overrun_end", 32'(overrun), 32'd0);

        // Overrun: 0x33 is dropped
        do_load(8'h11);
        wait_cs(4'd1, 70, "ovr_start");
        do_load(8'h22);
        do_load(8'h33);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_empty", 32'(empty), 32'd0);
        wait_idle("ovr_idle");
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Mid-frame reset during BIT3, then 0x81
        do_load(8'hC3);
        wait_cs(4'd5, 800, "rst_bit3");
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_txd", 32'(txd), 32'd1);
        chk("midrst_cs", 32'(CS), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        chk("midrst_overrun", 32'(overrun), 32'd0);
        do_load(8'h81);
        wait_idle("x81_idle");
        repeat (10) @(negedge clk);

        // Decoded line content
        exp_rx[0] = 8'hA5; exp_rx[1] = 8'h00; exp_rx[2] = 8'hFF; exp_rx[3] = 8'h3C;
        exp_rx[4] = 8'h55; exp_rx[5] = 8'h11; exp_rx[6] = 8'h22; exp_rx[7] = 8'h81;
        chk("rx_count", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_rx[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
